ewrapper_tx_framer: RTL and testbench

Transmit framer for the eLink TX path, in the slow (core) clock domain directly upstream of the TX serializer. Accepts emesh transactions through a 2-entry FIFO and converts each one into a 13-byte eLink packet padded to 16 bytes. Emits the packet as two 72-bit beats, already transposed into the per-pin, MSB-first layout the serializer shifts out. Honours the remote wait signal at packet boundaries.

---
 rtl/ewrapper_tx_framer.sv | 146 ++++++++++++++
 tb/tb_ewrapper_tx_framer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ewrapper_tx_framer.sv
// eLink TX framer: buffers emesh transactions in a small FIFO and emits each one
// as two 72-bit beats already transposed into the serializer's per-pin layout.
module ewrapper_tx_framer #(
  parameter int DEPTH = 2
) (
  input  logic        CLK_DIV_IN,
  input  logic        IO_RESET,
  input  logic        emesh_access_in,
  input  logic        emesh_write_in,
  input  logic [1:0]  emesh_datamode_in,
  input  logic [3:0]  emesh_ctrlmode_in,
  input  logic [31:0] emesh_dstaddr_in,
  input  logic [31:0] emesh_data_in,
  input  logic [31:0] emesh_srcaddr_in,
  output logic        emesh_wait_out,
  input  logic        TX_WAIT_IN,
  output logic [71:0] DATA_OUT_TO_IO,
  output logic        tx_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 103;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BEAT_A = 2'd1,
    BEAT_B = 2'd2
  } state_t;

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q, state_d;
  logic [71:0]   data_q, data_d;

  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic [EW-1:0] in_word;
  logic [EW-1:0] head;
  logic [71:0]   beat_a;
  logic [71:0]   beat_b;

  // Slot b of the beat goes out on cycle b; pin k carries bit k of each byte, MSB-first in time.
  function automatic logic [71:0] transpose_beat(input logic [63:0] bytes_in, input logic [7:0] frame);
    logic [71:0] beat;
    beat = {frame, 64'h0};
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < 8; k++) begin
        beat[8*k + 7 - b] = bytes_in[56 - 8*b + k];
      end
    end
    return beat;
  endfunction

  assign in_word        = {emesh_ctrlmode_in, emesh_datamode_in, emesh_write_in,
                           emesh_dstaddr_in, emesh_data_in, emesh_srcaddr_in};
  assign head           = mem_q[rd_ptr_q];
  assign fifo_empty     = (count_q == {CW{1'b0}});
  assign emesh_wait_out = (count_q == CW'(DEPTH));
  assign tx_busy        = !fifo_empty || (state_q != IDLE);
  assign DATA_OUT_TO_IO = data_q;

  // Frame stays high through B12 and drops for the three pad bytes of beat B.
  assign beat_a = transpose_beat({head[102:99], head[98:97], head[96], 1'b0,
                                  head[95:64], head[63:40]}, 8'hFF);
  assign beat_b = transpose_beat({head[39:32], head[31:0], 24'h000000}, 8'hF8);

  // FIFO next-state: push on accept, pop when beat B is registered.
  always_comb begin
    push     = emesh_access_in && !emesh_wait_out;
    pop      = (state_q == BEAT_A);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_word;
      wr_ptr_d        = wr_ptr_q + AW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1'b1);
      2'b01:   count_d = count_q - CW'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // Packet FSM; remote wait is only honoured at packet boundaries.
  always_comb begin
    state_d = state_q;
    data_d  = 72'h0;
    case (state_q)
      IDLE, BEAT_B: begin
        if (!fifo_empty && !TX_WAIT_IN) begin
          state_d = BEAT_A;
          data_d  = beat_a;
        end else begin
          state_d = IDLE;
          data_d  = 72'h0;
        end
      end
      BEAT_A: begin
        state_d = BEAT_B;
        data_d  = beat_b;
      end
      default: begin
        state_d = IDLE;
        data_d  = 72'h0;
      end
    endcase
  end

  // State, FIFO and output registers.
  always_ff @(posedge CLK_DIV_IN or posedge IO_RESET) begin
    if (IO_RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {EW{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      state_q  <= IDLE;
      data_q   <= 72'h0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: tb/tb_ewrapper_tx_framer.sv
// Scoreboard bench for ewrapper_tx_framer: expected beats are queued at accept
// time and compared whenever the framer drives a non-idle beat.
module tb_ewrapper_tx_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        access = 1'b0;
  logic        write = 1'b0;
  logic [1:0]  dm = 2'b00;
  logic [3:0]  ctrl = 4'h0;
  logic [31:0] dst = 32'h0;
  logic [31:0] data = 32'h0;
  logic [31:0] src = 32'h0;
  logic        wait_out;
  logic        tx_wait = 1'b0;
  logic [71:0] dout;
  logic        busy;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [71:0] exp_q[$];
  logic [8:0]  wtr;
  logic [8:0]  otr;

  ewrapper_tx_framer #(.DEPTH(2)) dut (
    .CLK_DIV_IN        (clk),
    .IO_RESET          (rst),
    .emesh_access_in   (access),
    .emesh_write_in    (write),
    .emesh_datamode_in (dm),
    .emesh_ctrlmode_in (ctrl),
    .emesh_dstaddr_in  (dst),
    .emesh_data_in     (data),
    .emesh_srcaddr_in  (src),
    .emesh_wait_out    (wait_out),
    .TX_WAIT_IN        (tx_wait),
    .DATA_OUT_TO_IO    (dout),
    .tx_busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [71:0] model_beat(input logic [0:7][7:0] by, input logic [7:0] fr);
    logic [71:0] o;
    o[71:64] = fr;
    for (int k = 0; k < 8; k++) begin
      for (int b = 0; b < 8; b++) begin
        o[8*k + 7 - b] = by[b][k];
      end
    end
    return o;
  endfunction

  task automatic push_expected();
    logic [0:15][7:0] pk;
    logic [0:7][7:0]  ba;
    logic [0:7][7:0]  bb;
    pk = {{ctrl, dm, write, 1'b0}, dst, data, src, 24'h000000};
    for (int b = 0; b < 8; b++) begin
      ba[b] = pk[b];
      bb[b] = pk[8 + b];
    end
    exp_q.push_back(model_beat(ba, 8'hFF));
    exp_q.push_back(model_beat(bb, 8'hF8));
  endtask

  always @(negedge clk) begin : scoreboard
    logic [71:0] e;
    if (!rst) begin
      if (dout !== 72'h0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", dout, 72'h0);
        end else begin
          e = exp_q.pop_front();
          chk("beat", dout, e);
        end
      end
      if (access && !wait_out) push_expected();
    end
  end

  task automatic send(input logic [3:0] c, input logic [1:0] m, input logic w,
                      input logic [31:0] a, input logic [31:0] d, input logic [31:0] s);
    ctrl = c; dm = m; write = w; dst = a; data = d; src = s;
    access = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!wait_out) break;
    end
    chk("send_accept", 72'(wait_out), 72'h0);
    @(posedge clk);
    #1;
    access = 1'b0;
  endtask

  task automatic send_rand();
    send(4'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0 && !busy) break;
      @(negedge clk);
    end
    chk("drain_queue", 72'(exp_q.size()), 72'h0);
    chk("drain_busy", 72'(busy), 72'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #2;
    chk("reset_dout", dout, 72'h0);
    chk("reset_wait", 72'(wait_out), 72'h0);
    chk("reset_busy", 72'(busy), 72'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // single write with hand-transposed expectations
    send(4'h0, 2'b10, 1'b1, 32'h80800000, 32'hDEADBEEF, 32'h12345678);
    @(negedge clk);
    chk("single_pre_dout", dout, 72'h0);
    chk("single_pre_busy", 72'(busy), 72'h1);
    @(posedge clk); @(negedge clk);
    chk("single_a", dout, 72'hFF_67_04_03_05_87_07_85_02);
    chk("single_a_pin1", 72'(dout[15:8]), 72'h85);
    @(posedge clk); @(negedge clk);
    chk("single_b", dout, 72'hF8_80_98_A8_78_88_B0_D0_80);
    chk("single_b_frame", 72'(dout[71:64]), 72'hF8);
    @(posedge clk); @(negedge clk);
    chk("single_idle", dout, 72'h0);
    chk("single_idle_busy", 72'(busy), 72'h0);

    // back-to-back: three transactions, six contiguous beats
    @(posedge clk);
    #1;
    fork
      begin
        send_rand();
        send_rand();
        send_rand();
      end
      begin
        for (int i = 0; i < 9; i++) begin
          @(negedge clk);
          wtr[i] = wait_out;
          otr[i] = (dout != 72'h0);
        end
      end
    join
    chk("b2b_wait_trace", 72'(wtr), 72'(9'b000010100));
    chk("b2b_beat_trace", 72'(otr), 72'(9'b011111100));
    drain();

    // remote wait asserted during beat A of the first of two packets
    @(posedge clk);
    #1;
    send_rand();
    send_rand();
    tx_wait = 1'b1;
    @(negedge clk);
    chk("rw_beat_a", 72'(dout[71:64]), 72'hFF);
    @(posedge clk); @(negedge clk);
    chk("rw_beat_b", 72'(dout[71:64]), 72'hF8);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      chk("rw_hold_dout", dout, 72'h0);
      chk("rw_hold_busy", 72'(busy), 72'h1);
    end
    @(posedge clk);
    #1 tx_wait = 1'b0;
    @(negedge clk);
    chk("rw_release_dout", dout, 72'h0);
    @(posedge clk); @(negedge clk);
    chk("rw_resume", 72'(dout[71:64]), 72'hFF);
    drain();

    // sustained input keeps the FIFO full while it is popped
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) send_rand();
    drain();

    // reset during beat A discards the packet
    @(posedge clk);
    #1;
    send_rand();
    @(posedge clk);
    #2;
    chk("rst_pre_frame", 72'(dout[71:64]), 72'hFF);
    rst = 1'b1;
    #1;
    chk("rst_dout", dout, 72'h0);
    chk("rst_busy", 72'(busy), 72'h0);
    chk("rst_wait", 72'(wait_out), 72'h0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    send(4'h5, 2'b01, 1'b0, 32'hCAFEF00D, 32'h0BADC0DE, 32'hA5A55A5A);
    drain();

    // idle
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_dout", dout, 72'h0);
      chk("idle_busy", 72'(busy), 72'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
